// File: rtl/rgbtoyuv444.sv
// rtl/rgbtoyuv444.sv - streaming RGB to studio-range BT.601 YUV444 converter
//
// Purpose: converts packed 8-bit RGB pixels (B[7:0], G[15:8], R[23:16], pad[31:24])
// into packed 8-bit YUV444 pixels (V[7:0], U[15:8], Y[23:16], 0[31:24]). All
// DATA_WIDTH/32 pixels of a beat are converted in parallel through a three-stage
// pipeline: coefficient products, rounded sums, then shifted and offset bytes.
//
// Ports:
//   aclk_i, rst_i          clock (rising edge), synchronous active-high reset
//   src_t_*_i / src_t_ready_o   RGB input stream (slave)
//   dst_t_*_o / dst_t_ready_i   YUV output stream (master)
//   strb/keep/last/id/dest/user sidebands travel with their beat unchanged
module rgbtoyuv444 #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 8
) (
  input  logic                    aclk_i,
  input  logic                    rst_i,
  input  logic                    src_t_valid_i,
  output logic                    src_t_ready_o,
  input  logic [DATA_WIDTH-1:0]   src_t_data_i,
  input  logic [DATA_WIDTH/8-1:0] src_t_strb_i,
  input  logic [DATA_WIDTH/8-1:0] src_t_keep_i,
  input  logic                    src_t_last_i,
  input  logic [ID_WIDTH-1:0]     src_t_id_i,
  input  logic [DEST_WIDTH-1:0]   src_t_dest_i,
  input  logic [USER_WIDTH-1:0]   src_t_user_i,
  output logic                    dst_t_valid_o,
  input  logic                    dst_t_ready_i,
  output logic [DATA_WIDTH-1:0]   dst_t_data_o,
  output logic [DATA_WIDTH/8-1:0] dst_t_strb_o,
  output logic [DATA_WIDTH/8-1:0] dst_t_keep_o,
  output logic                    dst_t_last_o,
  output logic [ID_WIDTH-1:0]     dst_t_id_o,
  output logic [DEST_WIDTH-1:0]   dst_t_dest_o,
  output logic [USER_WIDTH-1:0]   dst_t_user_o
);

  localparam int PIX = DATA_WIDTH / 32;
  localparam int SW  = DATA_WIDTH / 8;
  localparam int SBW = 2 * SW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  // Product index c: 0..2 -> Y from R,G,B; 3..5 -> U; 6..8 -> V.
  localparam logic signed [17:0] COEF [9] = '{
    18'sd66,  18'sd129,  18'sd25,
    -18'sd38, -18'sd74,  18'sd112,
    18'sd112, -18'sd94,  -18'sd18
  };

  logic [SBW-1:0] src_sb;
  assign src_sb = {src_t_strb_i, src_t_keep_i, src_t_last_i,
                   src_t_id_i, src_t_dest_i, src_t_user_i};

  logic                  s1_valid_q, s2_valid_q, s3_valid_q;
  logic [SBW-1:0]        s1_sb_q, s2_sb_q, s3_sb_q;
  logic signed [17:0]    s1_prod_d [PIX][9];
  logic signed [17:0]    s1_prod_q [PIX][9];
  logic signed [17:0]    s2_sum_d  [PIX][3];
  logic signed [17:0]    s2_sum_q  [PIX][3];
  logic [DATA_WIDTH-1:0] s3_data_d, s3_data_q;
  logic                  s1_ready, s2_ready, s3_ready;
  logic                  unused_pad;

  // A stage can load when empty or when its occupant leaves this cycle,
  // so bubbles collapse without a global stall.
  assign s3_ready      = !s3_valid_q || dst_t_ready_i;
  assign s2_ready      = !s2_valid_q || s3_ready;
  assign s1_ready      = !s1_valid_q || s2_ready;
  assign src_t_ready_o = s1_ready && !rst_i;

  always_comb begin
    unused_pad = 1'b0;
    for (int k = 0; k < PIX; k++) begin
      unused_pad = unused_pad ^ (^src_t_data_i[32*k+24 +: 8]);
      for (int c = 0; c < 9; c++) begin
        // Channel offset: R at +16, G at +8, B at +0 within the pixel.
        s1_prod_d[k][c] = COEF[c] *
          $signed({10'd0, src_t_data_i[32*k + 16 - 8*(c%3) +: 8]});
      end
    end
  end

  always_comb begin
    for (int k = 0; k < PIX; k++) begin
      for (int c = 0; c < 3; c++) begin
        s2_sum_d[k][c] = s1_prod_q[k][3*c] + s1_prod_q[k][3*c+1] +
                         s1_prod_q[k][3*c+2] + 18'sd128;
      end
    end
  end

  always_comb begin
    s3_data_d = '0;
    for (int k = 0; k < PIX; k++) begin
      // Results lie in [16,240]; only the low byte is kept.
      s3_data_d[32*k +: 32] = {8'h00,
                               8'((s2_sum_q[k][0] >>> 8) + 18'sd16),
                               8'((s2_sum_q[k][1] >>> 8) + 18'sd128),
                               8'((s2_sum_q[k][2] >>> 8) + 18'sd128)};
    end
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_sb_q    <= '0;
      s2_sb_q    <= '0;
      s3_sb_q    <= '0;
      s1_prod_q  <= '{default: '0};
      s2_sum_q   <= '{default: '0};
      s3_data_q  <= '0;
    end else begin
      if (s1_ready) s1_valid_q <= src_t_valid_i;
      if (s1_ready && src_t_valid_i) begin
        s1_prod_q <= s1_prod_d;
        s1_sb_q   <= src_sb;
      end
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s2_ready && s1_valid_q) begin
        s2_sum_q <= s2_sum_d;
        s2_sb_q  <= s1_sb_q;
      end
      if (s3_ready) s3_valid_q <= s2_valid_q;
      if (s3_ready && s2_valid_q) begin
        s3_data_q <= s3_data_d;
        s3_sb_q   <= s2_sb_q;
      end
    end
  end

  assign dst_t_valid_o = s3_valid_q;
  assign dst_t_data_o  = s3_data_q;
  assign {dst_t_strb_o, dst_t_keep_o, dst_t_last_o,
          dst_t_id_o, dst_t_dest_o, dst_t_user_o} = s3_sb_q;

endmodule
